prbs_checker: RTL and testbench

- Receive-side counterpart to the compliance pattern generator.
- Consumes the 10-bit TMDS symbol stream, as recovered by a deserializer, one word per valid cycle.
- Self-synchronizes a local PRBS15 reference to the stream, declares lock, then counts bit errors against the prediction.
- Used on loopback/bring-up boards to qualify the HDMI link without a scope.

---
 rtl/prbs_checker.sv | 222 ++++++++++++++++++++++
 tb/tb_prbs_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS15 receive checker for the 10-bit TMDS compliance stream.
// Seeds a local x^15+x^14+1 reference from two received words, confirms it
// over LOCK_COUNT further words, then free-runs and counts bit errors.
// Lock is dropped after LOSS_COUNT consecutive bad words.
module prbs_checker #(
    parameter int LOCK_COUNT = 4,   // 1..255
    parameter int LOSS_COUNT = 8,   // 1..255
    parameter int ERR_W      = 32   // must be >= 4 (holds a full word popcount)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             symbol_valid_i,
    input  logic [9:0]       symbol_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             error_o,
    output logic [ERR_W-1:0] error_count_o,
    output logic             sync_loss_o
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_TARGET = 8'(LOSS_COUNT);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]       state_reg,     state_next;
    logic [19:0]      history_reg,   history_next;
    logic [1:0]       seed_cnt_reg,  seed_cnt_next;
    logic [14:0]      lfsr_reg,      lfsr_next;
    logic [7:0]       match_cnt_reg, match_cnt_next;
    logic [7:0]       miss_cnt_reg,  miss_cnt_next;
    logic             locked_reg,    locked_next;
    logic             error_reg,     error_next;
    logic             sync_loss_reg, sync_loss_next;
    logic [ERR_W-1:0] err_cnt_reg,   err_cnt_next;

    // ------------------------------------------------------------------
    // Prediction datapath
    // lfsr_reg[14] is the newest serial bit, lfsr_reg[0] the oldest.
    // Bit i of the next word is b[n+i] = b[n+i-14] ^ b[n+i-15]. For the
    // first ten bits both taps still fall inside the current 15-bit state,
    // so every predicted bit is a single XOR of two state bits.
    // ------------------------------------------------------------------
    logic [9:0]  predicted;
    logic [14:0] lfsr_adv;
    logic [9:0]  diff;
    logic        word_match;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_predict
            assign predicted[gi] = lfsr_reg[gi + 1] ^ lfsr_reg[gi];
        end
    endgenerate

    // After ten more bits, the newest 15 are the prediction on top of the
    // five newest bits of the current state.
    assign lfsr_adv   = {predicted, lfsr_reg[14:10]};
    assign diff       = symbol_i ^ predicted;
    assign word_match = (diff == 10'd0);

    // ------------------------------------------------------------------
    // Popcount of the error word as a small adder tree:
    // five bit-pairs, then pair sums, then the final total.
    // ------------------------------------------------------------------
    logic [1:0] pair_sum [5];
    logic [3:0] bit_errors;

    generate
        for (gi = 0; gi < 5; gi++) begin : g_pairs
            assign pair_sum[gi] = {1'b0, diff[2*gi]} + {1'b0, diff[2*gi + 1]};
        end
    endgenerate

    // Sum the five pair counts into a 0..10 total.
    always_comb begin
        bit_errors = 4'd0;
        for (int i = 0; i < 5; i++) begin
            bit_errors = bit_errors + {2'b00, pair_sum[i]};
        end
    end

    // ------------------------------------------------------------------
    // Seeding view of the history: newest word enters at the top.
    // ------------------------------------------------------------------
    logic [19:0] hist_shift;
    logic [14:0] seed_candidate;

    assign hist_shift     = {symbol_i, history_reg[19:10]};
    assign seed_candidate = hist_shift[19:5];

    // ------------------------------------------------------------------
    // Saturating error accumulator; clear is applied before the add so a
    // coincident clear and error leaves just this word's count.
    // ------------------------------------------------------------------
    logic [ERR_W-1:0] err_base;
    logic [ERR_W:0]   err_sum_wide;
    logic [ERR_W-1:0] err_sum_sat;

    assign err_base     = clear_i ? '0 : err_cnt_reg;
    assign err_sum_wide = {1'b0, err_base} + (ERR_W + 1)'(bit_errors);
    assign err_sum_sat  = err_sum_wide[ERR_W] ? '1 : err_sum_wide[ERR_W-1:0];

    // ------------------------------------------------------------------
    // Next-state logic for the HUNT / VERIFY / LOCKED machine and the
    // status outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        history_next   = history_reg;
        seed_cnt_next  = seed_cnt_reg;
        lfsr_next      = lfsr_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        error_next     = 1'b0;
        sync_loss_next = clear_i ? 1'b0 : sync_loss_reg;
        err_cnt_next   = clear_i ? '0 : err_cnt_reg;

        if (symbol_valid_i) begin
            case (state_reg)
                ST_HUNT: begin
                    history_next = hist_shift;
                    if (seed_cnt_reg == 2'd0) begin
                        seed_cnt_next = 2'd1;
                    end else begin
                        // Two or more words seen: try the newest 15 bits.
                        // An all-zero state is the LFSR lock-up point, so
                        // keep sliding until a nonzero seed appears.
                        seed_cnt_next = 2'd2;
                        if (seed_candidate != 15'd0) begin
                            lfsr_next      = seed_candidate;
                            match_cnt_next = 8'd0;
                            state_next     = ST_VERIFY;
                        end
                    end
                end

                ST_VERIFY: begin
                    lfsr_next = lfsr_adv;
                    if (word_match) begin
                        match_cnt_next = match_cnt_reg + 8'd1;
                        if (match_cnt_reg + 8'd1 == LOCK_TARGET) begin
                            miss_cnt_next = 8'd0;
                            state_next    = ST_LOCKED;
                        end
                    end else begin
                        history_next  = 20'd0;
                        seed_cnt_next = 2'd0;
                        state_next    = ST_HUNT;
                    end
                end

                ST_LOCKED: begin
                    // Free-run: the reference is never reseeded from data,
                    // so isolated errors do not corrupt the prediction.
                    lfsr_next = lfsr_adv;
                    if (word_match) begin
                        miss_cnt_next = 8'd0;
                    end else begin
                        error_next    = 1'b1;
                        err_cnt_next  = err_sum_sat;
                        miss_cnt_next = miss_cnt_reg + 8'd1;
                        if (miss_cnt_reg + 8'd1 == LOSS_TARGET) begin
                            history_next   = 20'd0;
                            seed_cnt_next  = 2'd0;
                            sync_loss_next = 1'b1;
                            state_next     = ST_HUNT;
                        end
                    end
                end

                default: begin
                    history_next  = 20'd0;
                    seed_cnt_next = 2'd0;
                    state_next    = ST_HUNT;
                end
            endcase
        end

        locked_next = (state_next == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // Register update with asynchronous reset to HUNT and zeroed state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_HUNT;
            history_reg   <= 20'd0;
            seed_cnt_reg  <= 2'd0;
            lfsr_reg      <= 15'd0;
            match_cnt_reg <= 8'd0;
            miss_cnt_reg  <= 8'd0;
            locked_reg    <= 1'b0;
            error_reg     <= 1'b0;
            sync_loss_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            history_reg   <= history_next;
            seed_cnt_reg  <= seed_cnt_next;
            lfsr_reg      <= lfsr_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= locked_next;
            error_reg     <= error_next;
            sync_loss_reg <= sync_loss_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign locked_o      = locked_reg;
    assign error_o       = error_reg;
    assign error_count_o = err_cnt_reg;
    assign sync_loss_o   = sync_loss_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, bit errors, loss of sync, all-zero
// input, gapped valid with clear, async reset and counter saturation.
module tb_prbs_checker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        symbol_valid_i;
    logic [9:0]  symbol_i;
    logic        clear_i;

    logic        locked_o;
    logic        error_o;
    logic [31:0] error_count_o;
    logic        sync_loss_o;

    logic        s4_locked;
    logic        s4_error;
    logic [3:0]  s4_count;
    logic        s4_sync_loss;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [14:0] gen_state;

    always #5 clk_i = ~clk_i;

    prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .symbol_valid_i (symbol_valid_i),
        .symbol_i       (symbol_i),
        .clear_i        (clear_i),
        .locked_o       (locked_o),
        .error_o        (error_o),
        .error_count_o  (error_count_o),
        .sync_loss_o    (sync_loss_o)
    );

    prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(4)) dut_sat (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .symbol_valid_i (symbol_valid_i),
        .symbol_i       (symbol_i),
        .clear_i        (clear_i),
        .locked_o       (s4_locked),
        .error_o        (s4_error),
        .error_count_o  (s4_count),
        .sync_loss_o    (s4_sync_loss)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Serial PRBS15 generator: ten bits per word, bit 0 first.
    task automatic gen_word(output logic [9:0] w);
        logic b;
        for (int i = 0; i < 10; i++) begin
            b         = gen_state[1] ^ gen_state[0];
            w[i]      = b;
            gen_state = {b, gen_state[14:1]};
        end
    endtask

    // Drive one cycle of inputs (at negedge), let the DUT clock it, and
    // return at the following negedge where its outputs are sampled.
    task automatic apply(input logic v, input logic [9:0] d, input logic c);
        symbol_valid_i = v;
        symbol_i       = d;
        clear_i        = c;
        @(posedge clk_i);
        @(negedge clk_i);
        symbol_valid_i = 1'b0;
        clear_i        = 1'b0;
    endtask

    task automatic send_clean(input logic [9:0] flip, input logic c);
        logic [9:0] w;
        gen_word(w);
        apply(1'b1, w ^ flip, c);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        apply(1'b0, 10'd0, 1'b0);
        apply(1'b0, 10'd0, 1'b0);
        rst_i = 1'b0;
        apply(1'b0, 10'd0, 1'b0);
    endtask

    initial begin
        int         pulses;
        int         exp_cnt;
        logic [9:0] w;
        logic [9:0] bad;

        rst_i          = 1'b1;
        symbol_valid_i = 1'b0;
        symbol_i       = 10'd0;
        clear_i        = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_count", error_count_o, 32'd0);
        check("rst_sync_loss", 32'(sync_loss_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Clean stream from seed 0x7FFF
        gen_state = 15'h7FFF;
        pulses    = 0;
        for (int k = 1; k <= 1000; k++) begin
            send_clean(10'd0, 1'b0);
            pulses += int'(error_o);
            if (k == 5) check("clean_locked_w5", 32'(locked_o), 32'd0);
            if (k == 6) check("clean_locked_w6", 32'(locked_o), 32'd1);
        end
        check("clean_err_pulses", 32'(pulses), 32'd0);
        check("clean_count", error_count_o, 32'd0);
        check("clean_locked_end", 32'(locked_o), 32'd1);

        // Single bit flip, then a full-word flip
        send_clean(10'h008, 1'b0);
        check("flip1_error", 32'(error_o), 32'd1);
        check("flip1_count", error_count_o, 32'd1);
        check("flip1_locked", 32'(locked_o), 32'd1);
        send_clean(10'd0, 1'b0);
        check("flip1_error_clr", 32'(error_o), 32'd0);
        send_clean(10'h3FF, 1'b0);
        check("flip10_count", error_count_o, 32'd11);
        send_clean(10'd0, 1'b0);
        check("flip10_error_clr", 32'(error_o), 32'd0);
        check("flip10_locked", 32'(locked_o), 32'd1);

        // Loss of sync: eight bad words
        exp_cnt = 11;
        for (int k = 1; k <= 8; k++) begin
            gen_word(w);
            bad = (w == 10'h155) ? 10'h2AA : 10'h155;
            exp_cnt += $countones(w ^ bad);
            apply(1'b1, bad, 1'b0);
            if (k == 7) check("loss_locked_w7", 32'(locked_o), 32'd1);
        end
        check("loss_locked_w8", 32'(locked_o), 32'd0);
        check("loss_sync_loss", 32'(sync_loss_o), 32'd1);
        check("loss_error", 32'(error_o), 32'd1);
        check("loss_count", error_count_o, 32'(exp_cnt));

        // Resume clean stream: relock after 2+4 words
        for (int k = 1; k <= 6; k++) begin
            send_clean(10'd0, 1'b0);
            if (k == 5) check("relock_w5", 32'(locked_o), 32'd0);
            if (k == 6) check("relock_w6", 32'(locked_o), 32'd1);
        end
        check("relock_sync_loss", 32'(sync_loss_o), 32'd1);
        check("relock_count", error_count_o, 32'(exp_cnt));

        // Clear alone on an idle cycle
        apply(1'b0, 10'd0, 1'b1);
        check("clear_count", error_count_o, 32'd0);
        check("clear_sync_loss", 32'(sync_loss_o), 32'd0);
        check("clear_locked", 32'(locked_o), 32'd1);

        // All-zero input never locks
        do_reset();
        for (int k = 0; k < 50; k++) apply(1'b1, 10'd0, 1'b0);
        check("zero_locked", 32'(locked_o), 32'd0);
        check("zero_count", error_count_o, 32'd0);
        check("zero_error", 32'(error_o), 32'd0);

        // Gapped valid, then clear coinciding with a 2-bit error
        do_reset();
        gen_state = 15'h7FFF;
        for (int k = 1; k <= 6; k++) begin
            send_clean(10'd0, 1'b0);
            if (k == 5) check("gap_locked_w5", 32'(locked_o), 32'd0);
            if (k == 6) check("gap_locked_w6", 32'(locked_o), 32'd1);
            apply(1'b0, 10'd0, 1'b0);
        end
        check("gap_error_idle", 32'(error_o), 32'd0);
        send_clean(10'h001, 1'b0);
        check("gap_count1", error_count_o, 32'd1);
        apply(1'b0, 10'd0, 1'b0);
        check("gap_idle_error", 32'(error_o), 32'd0);
        send_clean(10'h021, 1'b1);
        check("clear_err_count", error_count_o, 32'd2);
        check("clear_err_sync_loss", 32'(sync_loss_o), 32'd0);
        check("clear_err_error", 32'(error_o), 32'd1);
        send_clean(10'h007, 1'b0);
        check("pre_rst_count", error_count_o, 32'd5);
        check("pre_rst_locked", 32'(locked_o), 32'd1);

        // Asynchronous reset away from the clock edge
        rst_i = 1'b1;
        #1;
        check("arst_locked", 32'(locked_o), 32'd0);
        check("arst_error", 32'(error_o), 32'd0);
        check("arst_count", error_count_o, 32'd0);
        check("arst_sync_loss", 32'(sync_loss_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Saturation with a 4-bit counter: 20 single-bit errors
        gen_state = 15'h7FFF;
        for (int k = 1; k <= 6; k++) send_clean(10'd0, 1'b0);
        check("sat_locked_start", 32'(s4_locked), 32'd1);
        for (int k = 0; k < 20; k++) begin
            send_clean(10'h010, 1'b0);
            send_clean(10'd0, 1'b0);
        end
        check("sat_count4", 32'(s4_count), 32'd15);
        check("sat_count32", error_count_o, 32'd20);
        check("sat_locked_end", 32'(s4_locked), 32'd1);
        check("sat_sync_loss", 32'(s4_sync_loss), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
